// File: rtl/sl_pkg.sv
// Shared types and constants for the second-layer window fetcher.
package sl_pkg;

    localparam int SL_ADDR_W         = 7;
    localparam int SL_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } sl_fetch_state_t;

    // Element 0 is the most significant byte, so a 32-bit read word maps byte 0 to [31:24].
    typedef logic [0:SL_BYTES_PER_WORD-1][7:0] sl_word_t;

endpackage

// File: rtl/sl_window_pos_counter.sv
// Window position counters (row base r, word column c) and last-position flag.
// SL_WINDOW_FETCH_COL_MAJOR_EN selects column-major stepping; default is row-major.
module sl_window_pos_counter
    import sl_pkg::*;
#(
    parameter int N         = 4,
    parameter int IMG_ROWS  = 6,
    parameter int ROW_WORDS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adv,
    input  logic                 clr,
    output logic [SL_ADDR_W-1:0] r,
    output logic [SL_ADDR_W-1:0] c,
    output logic                 last
);

    localparam logic [SL_ADDR_W-1:0] R_LAST = SL_ADDR_W'(IMG_ROWS - N);
    localparam logic [SL_ADDR_W-1:0] C_LAST = SL_ADDR_W'(ROW_WORDS - 1);

    logic [SL_ADDR_W-1:0] r_q, r_d;
    logic [SL_ADDR_W-1:0] c_q, c_d;

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        if (clr) begin
            r_d = '0;
            c_d = '0;
        end else if (adv) begin
`ifdef SL_WINDOW_FETCH_COL_MAJOR_EN
            if (r_q == R_LAST) begin
                r_d = '0;
                c_d = c_q + 1'b1;
            end else begin
                r_d = r_q + 1'b1;
            end
`else
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end

    assign r    = r_q;
    assign c    = c_q;
    assign last = (r_q == R_LAST) && (c_q == C_LAST);

endmodule

// File: rtl/sl_window_fetcher.sv
// Fetches an N-row x 4-byte IFM window from synchronous-read memory and hands it to layer 2.
// Traversal order follows sl_window_pos_counter (SL_WINDOW_FETCH_COL_MAJOR_EN = column-major).
module sl_window_fetcher
    import sl_pkg::*;
#(
    parameter int N         = 4,
    parameter int IMG_ROWS  = 6,
    parameter int ROW_WORDS = 2,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  windowpos_adv,
    output logic [SL_ADDR_W-1:0]  mem_rd_addr,
    output logic                  mem_rd_en,
    input  logic [31:0]           mem_rd_data,
    output sl_word_t [0:N-1]      window_buff_out,
    output logic                  ld_window_done,
    output logic                  cout_addr_generator,
    output logic                  busy
);

    localparam int L_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [L_W-1:0] L_LAST = L_W'(N - 1);

    sl_fetch_state_t state_q, state_d;

    logic [L_W-1:0]       l_q, l_d;
    logic [L_W-1:0]       l_dly_q, l_dly_d;
    logic                 rd_vld_q, rd_vld_d;
    sl_word_t             window_q [N];
    sl_word_t             window_d [N];

    logic [SL_ADDR_W-1:0] pos_r, pos_c;
    logic                 pos_last;
    logic                 pos_adv, pos_clr;
    logic [SL_ADDR_W-1:0] rd_addr;

    assign pos_adv = (state_q == READY) && windowpos_adv && !pos_last;
    assign pos_clr = (state_q == READY) && windowpos_adv &&  pos_last;

    sl_window_pos_counter #(
        .N         (N),
        .IMG_ROWS  (IMG_ROWS),
        .ROW_WORDS (ROW_WORDS)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .adv  (pos_adv),
        .clr  (pos_clr),
        .r    (pos_r),
        .c    (pos_c),
        .last (pos_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (l_q == L_LAST) state_d = DRAIN;
            DRAIN:   state_d = READY;
            READY:   if (windowpos_adv) state_d = pos_last ? IDLE : ISSUE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rd_en           = (state_q == ISSUE);
        mem_rd_addr         = (state_q == ISSUE) ? rd_addr : '0;
        ld_window_done      = (state_q == READY);
        busy                = (state_q != IDLE);
        cout_addr_generator = (state_q != IDLE) && pos_last;
    end

    assign rd_addr = SL_ADDR_W'(BASE_ADDR)
                   + (pos_r + SL_ADDR_W'(l_q)) * SL_ADDR_W'(ROW_WORDS)
                   + pos_c;

    // Line index and read-valid are delayed one cycle to line up with the memory's read latency.
    always_comb begin
        l_d      = ((state_q == ISSUE) && (l_q != L_LAST)) ? l_q + 1'b1 : '0;
        l_dly_d  = l_q;
        rd_vld_d = mem_rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_q      <= '0;
            l_dly_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            l_q      <= l_d;
            l_dly_q  <= l_dly_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            assign window_d[gi] = (rd_vld_q && (l_dly_q == L_W'(gi))) ? sl_word_t'(mem_rd_data)
                                                                      : window_q[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    window_q[gi] <= '0;
                end else begin
                    window_q[gi] <= window_d[gi];
                end
            end

            assign window_buff_out[gi] = window_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sl_window_fetcher.sv
// Self-checking bench for sl_window_fetcher against a position/address reference model.
// Honours SL_WINDOW_FETCH_COL_MAJOR_EN for the expected traversal order.
module tb_sl_window_fetcher;

    localparam int N         = 4;
    localparam int IMG_ROWS  = 6;
    localparam int ROW_WORDS = 2;
    localparam int BASE_ADDR = 0;
    localparam int NR        = IMG_ROWS - N + 1;
    localparam int NPOS      = NR * ROW_WORDS;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic                       windowpos_adv = 1'b0;
    logic [6:0]                 mem_rd_addr;
    logic                       mem_rd_en;
    logic [31:0]                mem_rd_data = '0;
    sl_pkg::sl_word_t [0:N-1]   window_buff_out;
    logic                       ld_window_done;
    logic                       cout_addr_generator;
    logic                       busy;

    int total = 0;
    int bad   = 0;
    logic [6:0] rd_q[$];

    always #5 clk = ~clk;

    sl_window_fetcher #(
        .N         (N),
        .IMG_ROWS  (IMG_ROWS),
        .ROW_WORDS (ROW_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .windowpos_adv       (windowpos_adv),
        .mem_rd_addr         (mem_rd_addr),
        .mem_rd_en           (mem_rd_en),
        .mem_rd_data         (mem_rd_data),
        .window_buff_out     (window_buff_out),
        .ld_window_done      (ld_window_done),
        .cout_addr_generator (cout_addr_generator),
        .busy                (busy)
    );

    function automatic logic [31:0] mem_word(int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    // Synchronous-read memory; also logs every issued address.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rd_data <= mem_word(int'(mem_rd_addr));
            rd_q.push_back(mem_rd_addr);
        end
    end

    // Reference traversal: window k -> (row base, column).
    function automatic int pos_r(int k);
`ifdef SL_WINDOW_FETCH_COL_MAJOR_EN
        return k % NR;
`else
        return k / ROW_WORDS;
`endif
    endfunction

    function automatic int pos_c(int k);
`ifdef SL_WINDOW_FETCH_COL_MAJOR_EN
        return k / NR;
`else
        return k % ROW_WORDS;
`endif
    endfunction

    function automatic int exp_addr(int k, int i);
        return (BASE_ADDR + (pos_r(k) + i) * ROW_WORDS + pos_c(k)) % 128;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        windowpos_adv = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ld(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (ld_window_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== 7'd0 ||
            ld_window_done !== 1'b0 || cout_addr_generator !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b en=%b addr=%0d ld=%b cout=%b, want all 0",
                     busy, mem_rd_en, mem_rd_addr, ld_window_done, cout_addr_generator);
        end
        total++;
        if (window_buff_out !== '0) begin
            bad++;
            $display("FAIL reset_window: got %h want 0", window_buff_out);
        end
        $display("test_reset: done");
    endtask

    task automatic test_first_window();
        rd_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (mem_rd_en !== 1'b1 || mem_rd_addr !== 7'(exp_addr(0, i))) begin
                bad++;
                $display("FAIL first_read[%0d]: got en=%b addr=%0d want en=1 addr=%0d",
                         i, mem_rd_en, mem_rd_addr, exp_addr(0, i));
            end
            total++;
            if (ld_window_done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL first_issue_flags[%0d]: got ld=%b busy=%b want ld=0 busy=1",
                         i, ld_window_done, busy);
            end
            tick();
        end
        total++;
        if (ld_window_done !== 1'b0 || mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL first_drain: got ld=%b en=%b want 0 0", ld_window_done, mem_rd_en);
        end
        tick();
        total++;
        if (ld_window_done !== 1'b1) begin
            bad++;
            $display("FAIL first_ld_cycle: got ld=%b at cycle %0d want 1", ld_window_done, N + 2);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (window_buff_out[i] !== mem_word(exp_addr(0, i))) begin
                bad++;
                $display("FAIL first_row[%0d]: got %h want %h", i, window_buff_out[i], mem_word(exp_addr(0, i)));
            end
        end
        total++;
        if (cout_addr_generator !== (NPOS == 1)) begin
            bad++;
            $display("FAIL first_cout: got %b want %b", cout_addr_generator, NPOS == 1);
        end
        $display("test_first_window: window 0 row2=%h", window_buff_out[2]);
    endtask

    task automatic test_advance();
        windowpos_adv = 1'b1;
        tick();
        windowpos_adv = 1'b0;
        for (int d = 1; d <= N + 1; d++) begin
            total++;
            if (ld_window_done !== 1'b0) begin
                bad++;
                $display("FAIL adv_ld_low[+%0d]: got %b want 0", d, ld_window_done);
            end
            if (d <= N) begin
                total++;
                if (mem_rd_en !== 1'b1 || mem_rd_addr !== 7'(exp_addr(1, d - 1))) begin
                    bad++;
                    $display("FAIL adv_read[+%0d]: got en=%b addr=%0d want en=1 addr=%0d",
                             d, mem_rd_en, mem_rd_addr, exp_addr(1, d - 1));
                end
            end
            tick();
        end
        total++;
        if (ld_window_done !== 1'b1) begin
            bad++;
            $display("FAIL adv_ld_high: got %b at +%0d want 1", ld_window_done, N + 2);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (window_buff_out[i] !== mem_word(exp_addr(1, i))) begin
                bad++;
                $display("FAIL adv_row[%0d]: got %h want %h", i, window_buff_out[i], mem_word(exp_addr(1, i)));
            end
        end
        $display("test_advance: window 1 base=%0d", exp_addr(1, 0));
    endtask

    task automatic test_walk(input bit immediate);
        bit ok;
        int dwell;
        do_reset();
        rd_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < NPOS; k++) begin
            wait_ld(ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL walk_timeout[%0d]: got no ld_window_done want ld=1 within 64 cycles", k);
                break;
            end
            total++;
            if (rd_q.size() != N) begin
                bad++;
                $display("FAIL walk_nreads[%0d]: got %0d want %0d", k, rd_q.size(), N);
            end else begin
                for (int i = 0; i < N; i++) begin
                    total++;
                    if (rd_q[i] !== 7'(exp_addr(k, i))) begin
                        bad++;
                        $display("FAIL walk_addr[%0d][%0d]: got %0d want %0d", k, i, rd_q[i], exp_addr(k, i));
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                total++;
                if (window_buff_out[i] !== mem_word(exp_addr(k, i))) begin
                    bad++;
                    $display("FAIL walk_row[%0d][%0d]: got %h want %h", k, i, window_buff_out[i], mem_word(exp_addr(k, i)));
                end
            end
            total++;
            if (cout_addr_generator !== (k == NPOS - 1)) begin
                bad++;
                $display("FAIL walk_cout[%0d]: got %b want %b", k, cout_addr_generator, k == NPOS - 1);
            end
            $display("test_walk: window %0d base=%0d cout=%b", k, exp_addr(k, 0), cout_addr_generator);
            rd_q.delete();
            dwell = immediate ? 0 : int'($urandom_range(1, 4));
            repeat (dwell) tick();
            total++;
            if (ld_window_done !== 1'b1) begin
                bad++;
                $display("FAIL walk_hold[%0d]: got ld=%b after dwell %0d want 1", k, ld_window_done, dwell);
            end
            windowpos_adv = 1'b1;
            tick();
            windowpos_adv = 1'b0;
            total++;
            if (ld_window_done !== 1'b0) begin
                bad++;
                $display("FAIL walk_drop[%0d]: got ld=%b want 0", k, ld_window_done);
            end
        end
        total++;
        if (busy !== 1'b0 || cout_addr_generator !== 1'b0 || mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL walk_end_idle: got busy=%b cout=%b en=%b want 0 0 0",
                     busy, cout_addr_generator, mem_rd_en);
        end
    endtask

    task automatic test_reset_mid_issue();
        bit ok;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== 7'd0 ||
            ld_window_done !== 1'b0 || cout_addr_generator !== 1'b0 || window_buff_out !== '0) begin
            bad++;
            $display("FAIL rst_issue_outputs: got busy=%b en=%b addr=%0d ld=%b win=%h want all 0",
                     busy, mem_rd_en, mem_rd_addr, ld_window_done, window_buff_out);
        end
        tick();
        tick();
        total++;
        if (window_buff_out !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_late_capture: got win=%h busy=%b want 0 0", window_buff_out, busy);
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_start_together: got busy=%b want 0", busy);
        end
        rd_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 7'(exp_addr(0, 0))) begin
            bad++;
            $display("FAIL rst_refetch_addr: got en=%b addr=%0d want en=1 addr=%0d",
                     mem_rd_en, mem_rd_addr, exp_addr(0, 0));
        end
        wait_ld(ok);
        total++;
        if (!ok || window_buff_out[N-1] !== mem_word(exp_addr(0, N - 1))) begin
            bad++;
            $display("FAIL rst_refetch_row: got ld=%b row=%h want ld=1 row=%h",
                     ld_window_done, window_buff_out[N-1], mem_word(exp_addr(0, N - 1)));
        end
        $display("test_reset_mid_issue: refetch base=%0d", exp_addr(0, 0));
    endtask

    task automatic test_ignored_inputs();
        bit ok;
        int pulse_at;
        do_reset();
        rd_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_at = int'($urandom_range(1, N));
        for (int cyc = 1; cyc <= N + 1; cyc++) begin
            windowpos_adv = (cyc == pulse_at);
            start = (cyc == N + 1 - pulse_at + 1);
            tick();
        end
        windowpos_adv = 1'b0;
        start = 1'b0;
        total++;
        if (ld_window_done !== 1'b1) begin
            bad++;
            $display("FAIL ign_ld_cycle: got ld=%b at cycle %0d want 1", ld_window_done, N + 2);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (window_buff_out[i] !== mem_word(exp_addr(0, i))) begin
                bad++;
                $display("FAIL ign_row0[%0d]: got %h want %h", i, window_buff_out[i], mem_word(exp_addr(0, i)));
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (ld_window_done !== 1'b1 || mem_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL ign_start_ready: got ld=%b en=%b want 1 0", ld_window_done, mem_rd_en);
        end
        rd_q.delete();
        windowpos_adv = 1'b1;
        tick();
        windowpos_adv = 1'b0;
        wait_ld(ok);
        total++;
        if (!ok || rd_q.size() == 0 || rd_q[0] !== 7'(exp_addr(1, 0))) begin
            bad++;
            $display("FAIL ign_next_base: got ld=%b nreads=%0d first=%0d want ld=1 first=%0d",
                     ld_window_done, rd_q.size(), (rd_q.size() != 0) ? int'(rd_q[0]) : -1, exp_addr(1, 0));
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (window_buff_out[i] !== mem_word(exp_addr(1, i))) begin
                bad++;
                $display("FAIL ign_row1[%0d]: got %h want %h", i, window_buff_out[i], mem_word(exp_addr(1, i)));
            end
        end
        $display("test_ignored_inputs: adv pulse at issue cycle %0d", pulse_at);
    endtask

    initial begin
        test_reset();
        test_first_window();
        test_advance();
        test_walk(1'b1);
        test_walk(1'b0);
        test_reset_mid_issue();
        test_ignored_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sl_window_fetcher.md
# sl_window_fetcher

- Upstream feeder for the second-layer convolution stage.
- Reads input-feature-map (IFM) words from a synchronous-read memory and assembles an N-row by 4-byte window.
- Presents the window on `window_buff_out` with a `ld_window_done` handshake, steps the window position on request, and flags the last position with `cout_addr_generator`.
- Replaces the ad-hoc address counters, so the second-layer controller only issues advance pulses.

## Interface
Parameters:
- `N`, 4, window height in rows; equals the consumer's `N`.
- `IMG_ROWS`, 6, IFM height in rows.
- `ROW_WORDS`, 2, 32-bit words per IFM row; a word is 4 bytes.
- `BASE_ADDR`, 0, first IFM word address. Constraint: `BASE_ADDR + IMG_ROWS*ROW_WORDS <= 128` and `IMG_ROWS >= N`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  begin a new image pass; sampled in IDLE only.
- `windowpos_adv`  in  1  consumer finished the current window; sampled in READY only.
- `mem_rd_addr`  out  7  IFM read address.
- `mem_rd_en`  out  1  read strobe.
- `mem_rd_data`  in  32  read data, valid 1 cycle after strobe. Bits [31:24] are byte 0.
- `window_buff_out`  out  [7:0] [0:N-1][0:3]  assembled window; row i = image row `r+i`, word column `c`.
- `ld_window_done`  out  1  level; window valid and stable.
- `cout_addr_generator`  out  1  level; current window is the last position.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Position counters: row base `r` in 0..IMG_ROWS-N, column `c` in 0..ROW_WORDS-1.
- Line counter `l` in 0..N-1.
- Read address = `BASE_ADDR + (r+l)*ROW_WORDS + c`, truncated to 7 bits.
- Default order is row-major: `c` increments fastest; on `c` wrap, `r` increments.
- FSM states:
  - **IDLE**: counters zero. `start` → ISSUE.
  - **ISSUE**: `mem_rd_en`=1; issue the read for line `l`, then `l++`. After the read for `l=N-1` → DRAIN.
  - **DRAIN**: capture the final word → READY.
  - **READY**: `ld_window_done`=1; window held. On `windowpos_adv`:
    - not last position: advance position, clear `l` → ISSUE.
    - last position: clear counters → IDLE.
- Capture: a delayed line index `l_d` (registered `l`) and a delayed valid (registered `mem_rd_en`) write `mem_rd_data` bytes into row `l_d`.
- `cout_addr_generator` = (READY or ISSUE or DRAIN) and `r==IMG_ROWS-N` and `c==ROW_WORDS-1`.
- `start` outside IDLE and `windowpos_adv` outside READY are ignored. No queueing.
- `window_buff_out` is not cleared between windows; rows are overwritten during refill. The consumer uses only `ld_window_done`.

## Timing
- Reset: state IDLE; all counters 0; `window_buff_out` all 0; `mem_rd_en`, `mem_rd_addr`, `ld_window_done`, `cout_addr_generator`, `busy` all 0.
- `start` sampled at edge 0 → ISSUE during cycles 1..N, DRAIN at N+1, `ld_window_done` high from cycle N+2.
- `windowpos_adv` sampled high at READY edge k:
  - `ld_window_done` low from k+1.
  - `ld_window_done` high again at k+N+2.
  - Steady-state window period is N+2 cycles plus consumer dwell.
- `ld_window_done` drops in the cycle after the advance is accepted; it never stays high across a refill.
- `rst` asserted in any state returns to IDLE at the next edge and discards any in-flight read.
- `start` and `rst` high together: reset wins.
- Single-position image (`IMG_ROWS==N`, `ROW_WORDS==1`): `cout_addr_generator` high from cycle 1 of the first fetch.

## Configuration
- `SL_WINDOW_FETCH_COL_MAJOR_EN`:
  - defined: column-major traversal; `r` increments fastest and wraps to 0, then `c` increments. The last position is unchanged.
  - undefined: row-major as above.
  - Fetch latency and handshake are identical in both modes.

## Structure
- Shared package `sl_pkg`:
  - FSM state enum `sl_fetch_state_t` (IDLE, ISSUE, DRAIN, READY).
  - `SL_ADDR_W = 7`, `SL_BYTES_PER_WORD = 4`.
  - Typedef `sl_word_t` for the 4-byte word array.
- One sub-module `sl_window_pos_counter`: holds `r`/`c`, advance input, last-position flag, and the `SL_WINDOW_FETCH_COL_MAJOR_EN` ordering.
- FSM, line counter and capture logic stay in the top.

## Test plan
Memory model: word at address `a` = `{a,a+1,a+2,a+3}` bytes. Defaults N=4, IMG_ROWS=6, ROW_WORDS=2.
- Reset then `start`:
  - reads 0,2,4,6 on cycles 1..4;
  - `ld_window_done` rises cycle 6;
  - row 2 = {4,5,6,7}; `cout_addr_generator`=0.
- Advance from window 1 → reads 1,3,5,7; `ld_window_done` low 1..5 cycles after acceptance, high at 6.
- Six windows with immediate advance:
  - base addresses 0,1,2,3,4,5;
  - `cout` high only on the 6th window;
  - 6th advance → IDLE, `busy`=0.
- With `SL_WINDOW_FETCH_COL_MAJOR_EN`: base addresses 0,2,4,1,3,5; `cout` high on the 6th window only.
- `rst` during ISSUE cycle 2:
  - next cycle IDLE, outputs at reset values;
  - the late read response is not captured;
  - a new `start` refetches from address 0.
- `windowpos_adv` during ISSUE and `start` during READY → no effect; window sequence unchanged.
